p2tdm: RTL and testbench
========================

# p2tdm

Parallel-to-TDM serializer: accepts one 256-bit audio frame (8 slots × 32 bits) per `tdmPdataValid` strobe and shifts it out MSB-first on a single TDM serial line with a frame-sync pulse. Sits downstream of `tdmMux`, consuming the selected parallel stream (register path or `tdm2p` bypass), and is the transmit-side counterpart of `tdm2p`. A one-frame holding buffer decouples the parallel writer from the serial frame boundary.

## Interface
- `SLOTS`, 8, TDM slots per frame.
- `SLOT_BITS`, 32, bits per slot; `SLOTS*SLOT_BITS` must equal 256.
- `FS_EARLY`, 0, 0: `tdmFsync` high during frame bit 0; 1: high during the last bit of the previous frame.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `bitEn` in 1: one-`clk` strobe per TDM bit period.
- `tdmPdataValid` in 1: one-cycle strobe; `tdmPdata` is valid this cycle.
- `tdmPdata` in 256: frame. Slot 0 in [255:224], slot 7 in [31:0].
- `tdmSdata` out 1: serial data, registered.
- `tdmFsync` out 1: frame sync, registered.
- `frameStart` out 1: one-`clk` pulse when a new frame is loaded into the shifter.
- `underrun` out 1: one-`clk` pulse when a frame boundary finds no pending data.
- `overflow` out 1: one-`clk` pulse when `tdmPdataValid` overwrites a pending, unsent frame.

## Operation
- Storage: `hold` (256 bits) plus `pending` flag; `shift` (256 bits); `bitCnt` (8 bits, 0..255).
- Write: `tdmPdataValid`=1 → `hold` ← `tdmPdata`, `pending` ← 1. If `pending` was already 1 and no boundary load consumes it this cycle → pulse `overflow` (newest data wins).
- FSM states:
  - IDLE: reset state. `bitEn` is ignored. Outputs are held at 0. Moves to RUN on the first `bitEn` with `pending`=1, which is also a boundary load.
  - RUN: stays in RUN until `rst`. There is no return to IDLE.
- Boundary load: happens on a `bitEn` with `bitCnt`=255 in RUN, or on the IDLE→RUN `bitEn`.
  - `shift` ← source; `bitCnt` ← 0; pulse `frameStart`.
  - Source, in priority order: `tdmPdata` if `tdmPdataValid` is 1 this cycle (bypass; `pending` stays 0); otherwise `hold` if `pending` (`pending` ← 0); otherwise all-zeros, and pulse `underrun`.
- Shifting: every `bitEn` in RUN, `tdmSdata` ← the current frame bit (bit 255 of the loaded source on the load cycle, then `shift[255]` after each left shift), and `bitCnt` increments.
- `tdmFsync`:
  - `FS_EARLY`=0: set with frame bit 0 and cleared with the next bit.
  - `FS_EARLY`=1: set with frame bit 255 and cleared with bit 0. No early pulse precedes the first frame after IDLE.
- `bitEn` with no load and IDLE: no state change except the write path.
- Reset mid-frame: the frame is abandoned. `pending`, `bitCnt`, `shift` and `hold` are cleared and the FSM returns to IDLE.

## Timing
- Reset values: `tdmSdata`=0, `tdmFsync`=0, `frameStart`=0, `underrun`=0, `overflow`=0, state IDLE.
- Outputs update on the `clk` edge at which `bitEn`=1. Each bit is stable for one full bit period, until the next `bitEn`.
- Latency: the first frame bit appears one `clk` after the first `bitEn` that follows a `tdmPdataValid`. `tdmPdataValid` and `bitEn` in the same IDLE cycle load that data directly.
- Steady state: the frame period is exactly 256 `bitEn` strobes. `frameStart` is asserted in the same cycle that bit 0 drives `tdmSdata`.
- The writer has until the `bitEn` of bit 255 (inclusive) to supply the next frame without underrun.
- `frameStart`, `underrun` and `overflow` are single-cycle pulses with no stretching. `underrun` and `frameStart` coincide.

## Structure
- Package `tdm_pkg`: `FRAME_BITS`=256, `SLOTS`, `SLOT_BITS`, the state enum {IDLE, RUN}, and a slot-index helper. These are shared with `tdm2p` and `tdmMux` users.
- One natural sub-module: `tdm_frame_shifter`, which holds `shift`, `bitCnt` and the load/shift/last-bit flag. The FSM, holding buffer and status pulses stay in `p2tdm`.

## Test plan
- Single frame: write `tdmPdata` = 0xA5A5...A5 (slot 0 = 0xDEADBEEF), then run `bitEn` every 4 `clk`. Required: serial output begins `1101_1110…`, `tdmFsync` is high for the first bit period only, and `frameStart` pulses once.
- Back-to-back: write frame B during frame A at bit 100. Required: B starts exactly 256 `bitEn` after A, with no `underrun` and no gap.
- Underrun: send no second write. Required: at the boundary `underrun`=`frameStart`=1, 256 zero bits are sent, and `tdmFsync` still pulses.
- Overflow and boundary collision:
  - Two writes before the boundary: required `overflow`=1 once, and the second word is transmitted.
  - A write coinciding with the bit-255 `bitEn`: required that word loads with no `overflow` and `pending`=0.
- `FS_EARLY`=1 with reset mid-frame: `tdmFsync` is aligned to bit 255 of the prior frame. A `rst` at bit 37 drives all outputs to 0 next `clk`, and the following write restarts from IDLE with bit 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared TDM frame geometry, FSM state type and slot helper
package tdm_pkg;
  localparam int SLOTS = 8;
  localparam int SLOT_BITS = 32;
  localparam int FRAME_BITS = 256;
  localparam int CNT_W = $clog2(FRAME_BITS);
  typedef enum logic {IDLE, RUN} state_e;
  function automatic int slot_msb(input int slot);
    return FRAME_BITS - 1 - slot * SLOT_BITS;
  endfunction
endpackage

// File: rtl/p2tdm_if.sv
// p2tdm_if: parallel frame input, bit strobe and serial/status outputs of p2tdm
interface p2tdm_if;
  import tdm_pkg::*;
  logic bitEn;
  logic tdmPdataValid;
  logic [FRAME_BITS-1:0] tdmPdata;
  logic tdmSdata;
  logic tdmFsync;
  logic frameStart;
  logic underrun;
  logic overflow;
  modport master(output bitEn, tdmPdataValid, tdmPdata,
                 input tdmSdata, tdmFsync, frameStart, underrun, overflow);
  modport slave(input bitEn, tdmPdataValid, tdmPdata,
                output tdmSdata, tdmFsync, frameStart, underrun, overflow);
endinterface

// File: rtl/tdm_frame_shifter.sv
// tdm_frame_shifter: frame shift register, bit counter and registered serial bit
module tdm_frame_shifter import tdm_pkg::*; #(
  parameter int W = FRAME_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 adv_i,
  input  logic [W-1:0]         src_i,
  output logic                 sdata_o,
  output logic [$clog2(W)-1:0] cnt_o
);
  localparam int CW = $clog2(W);
  logic [W-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sdata_q;
  always_comb begin
    shift_d = load_i ? src_i : adv_i ? shift_q << 1 : shift_q;
    cnt_d = load_i ? '0 : adv_i ? cnt_q + CW'(1) : cnt_q;
  end
  // serial bit is the MSB of the next shifter value, so bit 0 appears on the load edge
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q <= '0;
      sdata_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      if (load_i || adv_i) sdata_q <= shift_d[W-1];
    end
  end
  assign sdata_o = sdata_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/p2tdm.sv
// p2tdm: parallel-to-TDM serializer with one-frame holding buffer and frame sync
module p2tdm import tdm_pkg::*; #(
  parameter int SLOTS = tdm_pkg::SLOTS,
  parameter int SLOT_BITS = tdm_pkg::SLOT_BITS,
  parameter bit FS_EARLY = 1'b0
) (
  input logic     clk,
  input logic     rst,
  p2tdm_if.slave  bus
);
  state_e state_q, state_d;
  logic [FRAME_BITS-1:0] hold_q, src;
  logic [CNT_W-1:0] cnt;
  logic pending_q, pending_d, load, adv, none, fsync_d;
  logic fsync_q, fs_q, ur_q, ov_q;
  // a write on the boundary bitEn bypasses the holding buffer and wins over it
  always_comb begin
    load = bus.bitEn && (state_q == RUN ? &cnt : (pending_q || bus.tdmPdataValid));
    adv = bus.bitEn && state_q == RUN && !load;
    none = !bus.tdmPdataValid && !pending_q;
    src = bus.tdmPdataValid ? bus.tdmPdata : pending_q ? hold_q : '0;
    pending_d = load ? 1'b0 : bus.tdmPdataValid || pending_q;
    state_d = load ? RUN : state_q;
    fsync_d = FS_EARLY ? adv && cnt == CNT_W'(FRAME_BITS - 2) : load;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      pending_q <= 1'b0;
      fsync_q <= 1'b0;
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      if (bus.tdmPdataValid) hold_q <= bus.tdmPdata;
      if (load || adv) fsync_q <= fsync_d;
      fs_q <= load;
      ur_q <= load && none;
      ov_q <= bus.tdmPdataValid && pending_q && !load;
    end
  end
  tdm_frame_shifter #(.W(SLOTS * SLOT_BITS)) u_shifter (
    .clk(clk),
    .rst(rst),
    .load_i(load),
    .adv_i(adv),
    .src_i(src),
    .sdata_o(bus.tdmSdata),
    .cnt_o(cnt)
  );
  assign bus.tdmFsync = fsync_q;
  assign bus.frameStart = fs_q;
  assign bus.underrun = ur_q;
  assign bus.overflow = ov_q;
endmodule

// File: tb/tb_p2tdm.sv
// tb_p2tdm: directed checks of p2tdm with late (FS_EARLY=0) and early (FS_EARLY=1) sync
module tb_p2tdm;
  import tdm_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  p2tdm_if bus0();
  p2tdm_if bus1();
  assign bus1.bitEn = bus0.bitEn;
  assign bus1.tdmPdataValid = bus0.tdmPdataValid;
  assign bus1.tdmPdata = bus0.tdmPdata;
  p2tdm #(.FS_EARLY(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  p2tdm #(.FS_EARLY(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  int vecs = 0, errs = 0;
  logic sd, fy, fy1, fst, ur, ov, late;
  logic fst0, ur0, fy0, fy10, ov0, fy1_last;
  int fs_cnt, ur_cnt, ov_cnt, fy_cnt, fy1_cnt, late_cnt;
  logic [255:0] rx, fa, fb, fd1, fd2, fe, ff, fg, fk, fh, zero;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [255:0] d);
    bus0.tdmPdataValid = v;
    bus0.tdmPdata = d;
    bus0.bitEn = 1'b1;
    @(posedge clk); #1;
    bus0.bitEn = 1'b0;
    bus0.tdmPdataValid = 1'b0;
    sd = bus0.tdmSdata; fy = bus0.tdmFsync; fy1 = bus1.tdmFsync;
    fst = bus0.frameStart; ur = bus0.underrun; ov = bus0.overflow;
    @(posedge clk); #1;
    late = bus0.frameStart | bus0.underrun | bus0.overflow;
    repeat (2) begin @(posedge clk); #1; end
  endtask
  task automatic frame(input int n, input int w1, input logic [255:0] d1,
                       input int w2, input logic [255:0] d2);
    rx = '0;
    fs_cnt = 0; ur_cnt = 0; ov_cnt = 0; fy_cnt = 0; fy1_cnt = 0; late_cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(i == w1 || i == w2, i == w2 ? d2 : d1);
      rx[255 - i] = sd;
      if (i == 0) begin fst0 = fst; ur0 = ur; fy0 = fy; fy10 = fy1; ov0 = ov; end
      if (i == 255) fy1_last = fy1;
      fs_cnt += int'(fst); ur_cnt += int'(ur); ov_cnt += int'(ov);
      fy_cnt += int'(fy); fy1_cnt += int'(fy1); late_cnt += int'(late);
    end
  endtask
  initial begin
    fa = {32'hDEADBEEF, {7{32'hA5A5A5A5}}};
    fb = {4{64'h0123_4567_89AB_CDEF}};
    fd1 = {8{32'h1111_1111}};
    fd2 = {8{32'hC3C3_0F0F}};
    fe = {8{32'h7E81_55AA}};
    ff = {8{32'h2222_2222}};
    fg = {8{32'hFFFF_0000}};
    fk = {8{32'h3333_3333}};
    fh = {8{32'h8000_0001}};
    zero = '0;
    bus0.bitEn = 1'b0;
    bus0.tdmPdataValid = 1'b0;
    bus0.tdmPdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_sdata", 256'(bus0.tdmSdata), 256'(0));
    chk("reset_fsync", 256'(bus0.tdmFsync), 256'(0));
    chk("reset_fstart", 256'(bus0.frameStart), 256'(0));
    chk("reset_underrun", 256'(bus0.underrun), 256'(0));
    chk("reset_overflow", 256'(bus0.overflow), 256'(0));
    step(1'b0, zero);
    chk("idle_biten_fstart", 256'(fst), 256'(0));
    chk("idle_biten_underrun", 256'(ur), 256'(0));
    bus0.tdmPdataValid = 1'b1;
    bus0.tdmPdata = fa;
    @(posedge clk); #1;
    bus0.tdmPdataValid = 1'b0;
    chk("first_write_overflow", 256'(bus0.overflow), 256'(0));
    frame(256, 100, fb, -1, zero);
    chk("a_data", rx, fa);
    chk("a_first_byte", 256'(rx[255:248]), 256'(8'hDE));
    chk("a_slot0", 256'(rx[slot_msb(0) -: 32]), 256'(32'hDEADBEEF));
    chk("a_fstart_bit0", 256'(fst0), 256'(1));
    chk("a_fstart_count", 256'(fs_cnt), 256'(1));
    chk("a_fsync_bit0", 256'(fy0), 256'(1));
    chk("a_fsync_count", 256'(fy_cnt), 256'(1));
    chk("a_early_fsync_bit0", 256'(fy10), 256'(0));
    chk("a_early_fsync_bit255", 256'(fy1_last), 256'(1));
    chk("a_early_fsync_count", 256'(fy1_cnt), 256'(1));
    chk("a_underrun_count", 256'(ur_cnt), 256'(0));
    chk("a_overflow_count", 256'(ov_cnt), 256'(0));
    chk("a_pulse_stretch", 256'(late_cnt), 256'(0));
    frame(256, -1, zero, -1, zero);
    chk("b_data", rx, fb);
    chk("b_fstart_bit0", 256'(fst0), 256'(1));
    chk("b_no_underrun", 256'(ur_cnt), 256'(0));
    chk("b_early_fsync_clear_bit0", 256'(fy10), 256'(0));
    chk("b_early_fsync_count", 256'(fy1_cnt), 256'(1));
    frame(256, 10, fd1, 20, fd2);
    chk("c_zero_data", rx, zero);
    chk("c_underrun_bit0", 256'(ur0), 256'(1));
    chk("c_fstart_bit0", 256'(fst0), 256'(1));
    chk("c_underrun_count", 256'(ur_cnt), 256'(1));
    chk("c_fsync_bit0", 256'(fy0), 256'(1));
    chk("c_overflow_count", 256'(ov_cnt), 256'(1));
    chk("c_pulse_stretch", 256'(late_cnt), 256'(0));
    frame(256, 50, ff, -1, zero);
    chk("d_newest_wins", rx, fd2);
    chk("d_no_underrun", 256'(ur_cnt), 256'(0));
    chk("d_overflow_count", 256'(ov_cnt), 256'(0));
    frame(256, 0, fe, -1, zero);
    chk("e_bypass_data", rx, fe);
    chk("e_fstart_bit0", 256'(fst0), 256'(1));
    chk("e_no_overflow", 256'(ov0), 256'(0));
    chk("e_no_underrun", 256'(ur_cnt), 256'(0));
    frame(256, 5, fg, -1, zero);
    chk("z_pending_cleared_underrun", 256'(ur0), 256'(1));
    chk("z_zero_data", rx, zero);
    frame(38, 30, fk, -1, zero);
    chk("g_fstart_bit0", 256'(fst0), 256'(1));
    chk("g_no_underrun", 256'(ur0), 256'(0));
    chk("g_prefix", rx >> 218, fg >> 218);
    chk("g_bit37_high", 256'(sd), 256'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_sdata", 256'(bus0.tdmSdata), 256'(0));
    chk("midrst_fsync", 256'(bus0.tdmFsync | bus1.tdmFsync), 256'(0));
    chk("midrst_pulses", 256'(bus0.frameStart | bus0.underrun | bus0.overflow), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    step(1'b0, zero);
    chk("postrst_idle_fstart", 256'(fst), 256'(0));
    chk("postrst_idle_sdata", 256'(sd), 256'(0));
    step(1'b1, fh);
    chk("restart_fstart", 256'(fst), 256'(1));
    chk("restart_bit0", 256'(sd), 256'(fh[255]));
    chk("restart_fsync", 256'(fy), 256'(1));
    chk("restart_no_early_fsync", 256'(fy1), 256'(0));
    chk("restart_no_underrun", 256'(ur), 256'(0));
    step(1'b0, zero);
    chk("restart_bit1", 256'(sd), 256'(fh[254]));
    chk("restart_fsync_clear", 256'(fy), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
